// File: rtl/mpq_sched_if.sv
// Command bus between mpq_sched and the max-priority-queue datapath.
// master = scheduler side (drives commands), slave = queue side (drives busy/done).
interface mpq_sched_if;
    logic       mpq_cmd_valid;
    logic [2:0] mpq_cmd;
    logic [7:0] mpq_index;
    logic [7:0] mpq_value;
    logic       mpq_busy;
    logic       mpq_done;

    modport master (
        output mpq_cmd_valid,
        output mpq_cmd,
        output mpq_index,
        output mpq_value,
        input  mpq_busy,
        input  mpq_done
    );

    modport slave (
        input  mpq_cmd_valid,
        input  mpq_cmd,
        input  mpq_index,
        input  mpq_value,
        output mpq_busy,
        output mpq_done
    );
endinterface

// File: rtl/mpq_sched.sv
// Round-robin two-port command scheduler for the max-priority queue, with shadow occupancy.
// Optional per-requester grant/error counters are enabled by defining MPQ_SCHED_STATS_EN.
module mpq_sched #(
    parameter int DEPTH   = 255,
    parameter int BUSY_TO = 4,
    parameter int OCC_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [2:0]       req0_cmd,
    input  logic [7:0]       req0_index,
    input  logic [7:0]       req0_value,
    output logic             req0_ack,
    output logic             req0_err,
    input  logic             req1_valid,
    input  logic [2:0]       req1_cmd,
    input  logic [7:0]       req1_index,
    input  logic [7:0]       req1_value,
    output logic             req1_ack,
    output logic             req1_err,
    input  logic             occ_init_valid,
    input  logic [OCC_W-1:0] occ_init,
    mpq_sched_if.master      mpq,
    output logic [OCC_W-1:0] occ,
    output logic             sched_busy
`ifdef MPQ_SCHED_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
    output logic [15:0]      err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_CMPL,
        RESP
    } state_t;

    localparam int CNT_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
    localparam int CMP_W = (OCC_W > 8) ? OCC_W : 8;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TO - 1);

    localparam logic [2:0] CMD_EXTRACT  = 3'd1;
    localparam logic [2:0] CMD_INCREASE = 3'd2;
    localparam logic [2:0] CMD_INSERT   = 3'd3;
    localparam logic [2:0] CMD_WRITEOUT = 3'd4;

    state_t           state, state_n;
    logic             grant, grant_n;
    logic             last_grant, last_n;
    logic [2:0]       cmd_q, cmd_n;
    logic [7:0]       index_q, index_n;
    logic [7:0]       value_q, value_n;
    logic             err_q, err_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [OCC_W-1:0] occ_n;

    logic             pick;
    logic [2:0]       sel_cmd;
    logic [7:0]       sel_index;
    logic [7:0]       sel_value;
    logic             reject;
    logic             cmpl;

    // Arbitration and legality check of the candidate request, against the current occupancy
    always_comb begin
        pick = 1'b0;
        if (req0_valid && req1_valid) begin
            pick = ~last_grant;
        end else if (req1_valid) begin
            pick = 1'b1;
        end

        sel_cmd   = pick ? req1_cmd   : req0_cmd;
        sel_index = pick ? req1_index : req0_index;
        sel_value = pick ? req1_value : req0_value;

        reject = 1'b0;
        case (sel_cmd)
            CMD_EXTRACT:  reject = (occ == '0);
            CMD_INCREASE: reject = (CMP_W'(sel_index) >= CMP_W'(occ));
            CMD_INSERT:   reject = (occ == OCC_FULL);
            3'd5, 3'd6, 3'd7: reject = 1'b1;
            default:      reject = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last_grant;
        cmd_n   = cmd_q;
        index_n = index_q;
        value_n = value_q;
        err_n   = err_q;
        cnt_n   = cnt;
        occ_n   = occ;
        cmpl    = 1'b0;

        case (state)
            IDLE: begin
                if (occ_init_valid) begin
                    occ_n = occ_init;
                end else if (req0_valid || req1_valid) begin
                    grant_n = pick;
                    last_n  = pick;
                    cmd_n   = sel_cmd;
                    index_n = sel_index;
                    value_n = sel_value;
                    err_n   = reject;
                    cnt_n   = '0;
                    state_n = reject ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (mpq.mpq_busy) begin
                    state_n = WAIT_CMPL;
                end else if (cnt == CNT_LAST) begin
                    err_n   = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_CMPL: begin
                // Write-out signals completion with done; every other command by dropping busy
                cmpl = (cmd_q == CMD_WRITEOUT) ? mpq.mpq_done : ~mpq.mpq_busy;
                if (cmpl) begin
                    if (cmd_q == CMD_INSERT) begin
                        occ_n = occ + OCC_W'(1);
                    end else if (cmd_q == CMD_EXTRACT) begin
                        occ_n = occ - OCC_W'(1);
                    end
                    err_n   = 1'b0;
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cmd_q      <= '0;
            index_q    <= '0;
            value_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
            occ        <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_n;
            cmd_q      <= cmd_n;
            index_q    <= index_n;
            value_q    <= value_n;
            err_q      <= err_n;
            cnt        <= cnt_n;
            occ        <= occ_n;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mpq.mpq_cmd_valid <= 1'b0;
            mpq.mpq_cmd       <= '0;
            mpq.mpq_index     <= '0;
            mpq.mpq_value     <= '0;
            req0_ack          <= 1'b0;
            req0_err          <= 1'b0;
            req1_ack          <= 1'b0;
            req1_err          <= 1'b0;
            sched_busy        <= 1'b0;
        end else begin
            mpq.mpq_cmd_valid <= (state_n == ISSUE);
            mpq.mpq_cmd       <= (state_n == ISSUE) ? cmd_n   : '0;
            mpq.mpq_index     <= (state_n == ISSUE) ? index_n : '0;
            mpq.mpq_value     <= (state_n == ISSUE) ? value_n : '0;
            req0_ack          <= (state_n == RESP) && !grant_n;
            req0_err          <= (state_n == RESP) && !grant_n && err_n;
            req1_ack          <= (state_n == RESP) && grant_n;
            req1_err          <= (state_n == RESP) && grant_n && err_n;
            sched_busy        <= (state_n != IDLE);
        end
    end

`ifdef MPQ_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            err_cnt    <= '0;
        end else begin
            if (req0_ack && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (req1_ack && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
            if ((req0_err || req1_err) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mpq_sched.sv
// Scoreboard bench for mpq_sched: stimulus pushes expected commands/acks, a monitor pops and compares.
// A small queue model answers issued commands with a programmable busy length and a done pulse for write-out.
module tb_mpq_sched;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [2:0] req0_cmd;
    logic [7:0] req0_index;
    logic [7:0] req0_value;
    logic       req0_ack;
    logic       req0_err;
    logic       req1_valid;
    logic [2:0] req1_cmd;
    logic [7:0] req1_index;
    logic [7:0] req1_value;
    logic       req1_ack;
    logic       req1_err;
    logic       occ_init_valid;
    logic [7:0] occ_init;
    logic [7:0] occ;
    logic       sched_busy;
`ifdef MPQ_SCHED_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [15:0] err_cnt;
`endif

    mpq_sched_if mpq_bus ();

    mpq_sched #(
        .DEPTH   (255),
        .BUSY_TO (4),
        .OCC_W   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_cmd       (req0_cmd),
        .req0_index     (req0_index),
        .req0_value     (req0_value),
        .req0_ack       (req0_ack),
        .req0_err       (req0_err),
        .req1_valid     (req1_valid),
        .req1_cmd       (req1_cmd),
        .req1_index     (req1_index),
        .req1_value     (req1_value),
        .req1_ack       (req1_ack),
        .req1_err       (req1_err),
        .occ_init_valid (occ_init_valid),
        .occ_init       (occ_init),
        .mpq            (mpq_bus.master),
        .occ            (occ),
        .sched_busy     (sched_busy)
`ifdef MPQ_SCHED_STATS_EN
        ,
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1),
        .err_cnt        (err_cnt)
`endif
    );

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] index;
        logic [7:0] value;
    } cmd_t;

    typedef struct {
        bit         port;
        bit         err;
        logic [7:0] occ;
    } ack_t;

    cmd_t exp_cmd[$];
    ack_t exp_ack[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_len = 1;
    bit never_busy = 0;
    bit model_clear = 0;
    int done_cyc = -1;
    int last_ack_cyc = -1;
    int lat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue model: busy rises the cycle after the strobe and holds busy_len cycles; write-out then pulses done
    initial begin
        int phase;
        int left;
        logic [2:0] mc;
        phase = 0;
        left = 0;
        mc = 3'd0;
        mpq_bus.mpq_busy = 1'b0;
        mpq_bus.mpq_done = 1'b0;
        forever begin
            @(negedge clk);
            if (model_clear) begin
                phase = 0;
                mpq_bus.mpq_busy = 1'b0;
                mpq_bus.mpq_done = 1'b0;
            end else begin
                case (phase)
                    0: if (mpq_bus.mpq_cmd_valid && !never_busy) begin
                        mc = mpq_bus.mpq_cmd;
                        phase = 1;
                    end
                    1: begin
                        mpq_bus.mpq_busy = 1'b1;
                        left = busy_len;
                        phase = 2;
                    end
                    2: begin
                        left--;
                        if (left <= 0) begin
                            mpq_bus.mpq_busy = 1'b0;
                            phase = (mc == 3'd4) ? 3 : 0;
                        end
                    end
                    3: begin
                        mpq_bus.mpq_done = 1'b1;
                        done_cyc = cyc;
                        phase = 4;
                    end
                    default: begin
                        mpq_bus.mpq_done = 1'b0;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: every command strobe and every ack must match the head of its queue
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mpq_bus.mpq_cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    checkOutput("cmd_valid_unexpected", 32'(mpq_bus.mpq_cmd_valid), 32'd0);
                end else begin
                    cmd_t e;
                    e = exp_cmd.pop_front();
                    checkOutput("mpq_cmd", 32'(mpq_bus.mpq_cmd), 32'(e.cmd));
                    checkOutput("mpq_index", 32'(mpq_bus.mpq_index), 32'(e.index));
                    checkOutput("mpq_value", 32'(mpq_bus.mpq_value), 32'(e.value));
                end
            end
            if (req0_ack || req1_ack) begin
                if (exp_ack.size() == 0) begin
                    checkOutput("ack_unexpected", 32'({req1_ack, req0_ack}), 32'd0);
                end else begin
                    ack_t a;
                    a = exp_ack.pop_front();
                    checkOutput("ack_port", 32'({req1_ack, req0_ack}), a.port ? 32'd2 : 32'd1);
                    checkOutput("ack_err", 32'(a.port ? req1_err : req0_err), 32'(a.err));
                    checkOutput("ack_occ", 32'(occ), 32'(a.occ));
                end
            end
        end
    end

    task automatic load_occ(input logic [7:0] v);
        @(negedge clk);
        occ_init_valid = 1'b1;
        occ_init = v;
        @(negedge clk);
        occ_init_valid = 1'b0;
        checkOutput("occ_load", 32'(occ), 32'(v));
    endtask

    task automatic applyStimulus(input bit port, input logic [2:0] cmd, input logic [7:0] idx,
                                 input logic [7:0] val, input bit exp_err, input bit issued,
                                 input logic [7:0] exp_occ, output int latency);
        cmd_t c;
        ack_t a;
        int start;
        c.cmd = cmd;
        c.index = idx;
        c.value = val;
        a.port = port;
        a.err = exp_err;
        a.occ = exp_occ;
        if (issued) exp_cmd.push_back(c);
        exp_ack.push_back(a);
        @(negedge clk);
        if (port) begin
            req1_valid = 1'b1; req1_cmd = cmd; req1_index = idx; req1_value = val;
        end else begin
            req0_valid = 1'b1; req0_cmd = cmd; req0_index = idx; req0_value = val;
        end
        start = cyc;
        latency = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (port ? req1_ack : req0_ack) begin
                latency = cyc - start;
                last_ack_cyc = cyc;
                break;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (latency < 0) checkOutput("ack_timeout", 32'(port ? req1_ack : req0_ack), 32'd1);
    endtask

    task automatic tie_round();
        cmd_t c;
        ack_t a;
        bit ok;
        c.cmd = 3'd0; c.index = 8'd0; c.value = 8'd0;
        exp_cmd.push_back(c);
        exp_cmd.push_back(c);
        a.port = 1'b0; a.err = 1'b0; a.occ = occ;
        exp_ack.push_back(a);
        a.port = 1'b1;
        exp_ack.push_back(a);
        @(negedge clk);
        req0_valid = 1'b1; req0_cmd = 3'd0; req0_index = 8'd0; req0_value = 8'd0;
        req1_valid = 1'b1; req1_cmd = 3'd0; req1_index = 8'd0; req1_value = 8'd0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req0_ack) req0_valid = 1'b0;
            if (req1_ack) req1_valid = 1'b0;
            if (!req0_valid && !req1_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("tie_timeout", 32'({req1_valid, req0_valid}), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        cmd_t c;
        rst = 1'b0;
        req0_valid = 0; req0_cmd = 0; req0_index = 0; req0_value = 0;
        req1_valid = 0; req1_cmd = 0; req1_index = 0; req1_value = 0;
        occ_init_valid = 0; occ_init = 0;
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_req0_ack", 32'(req0_ack), 32'd0);
        checkOutput("rst_req1_ack", 32'(req1_ack), 32'd0);
        checkOutput("rst_cmd_valid", 32'(mpq_bus.mpq_cmd_valid), 32'd0);
        checkOutput("rst_occ", 32'(occ), 32'd0);
        checkOutput("rst_sched_busy", 32'(sched_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Two ties in a row: requester 0 wins both since last_grant ends on requester 1 each round
        busy_len = 1;
        tie_round();
        tie_round();

        // Extract on empty is rejected without touching the queue, ack one cycle after the grant cycle
        applyStimulus(1'b1, 3'd1, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0, lat);
        checkOutput("lat_reject", 32'(lat), 32'd1);

        load_occ(8'd5);
        busy_len = 3;
        applyStimulus(1'b0, 3'd3, 8'd0, 8'h40, 1'b0, 1'b1, 8'd6, lat);

        busy_len = 1;
        applyStimulus(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd6, lat);
        checkOutput("lat_accept", 32'(lat), 32'd4);

        // Queue never answers: 4 WAIT_BUSY cycles then error ack
        never_busy = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b1, 8'd6, lat);
        checkOutput("lat_timeout", 32'(lat), 32'd6);
        never_busy = 1'b0;

        load_occ(8'd3);
        applyStimulus(1'b0, 3'd2, 8'd3, 8'h11, 1'b1, 1'b0, 8'd3, lat);
        applyStimulus(1'b0, 3'd2, 8'd2, 8'hFF, 1'b0, 1'b1, 8'd3, lat);
        busy_len = 2;
        applyStimulus(1'b0, 3'd4, 8'd0, 8'd0, 1'b0, 1'b1, 8'd3, lat);
        checkOutput("done_to_ack", 32'(last_ack_cyc - done_cyc), 32'd1);

        // Full boundary and illegal codes
        busy_len = 1;
        load_occ(8'd255);
        applyStimulus(1'b1, 3'd3, 8'd0, 8'h22, 1'b1, 1'b0, 8'd255, lat);
        applyStimulus(1'b0, 3'd1, 8'd0, 8'd0, 1'b0, 1'b1, 8'd254, lat);
        applyStimulus(1'b1, 3'd3, 8'd0, 8'h33, 1'b0, 1'b1, 8'd255, lat);
        applyStimulus(1'b0, 3'd3, 8'd0, 8'h44, 1'b1, 1'b0, 8'd255, lat);
        applyStimulus(1'b1, 3'd5, 8'd0, 8'd0, 1'b1, 1'b0, 8'd255, lat);
        applyStimulus(1'b0, 3'd7, 8'd0, 8'd0, 1'b1, 1'b0, 8'd255, lat);

        // Reset while the queue is still busy: command is dropped with no ack
        load_occ(8'd4);
        busy_len = 20;
        c.cmd = 3'd1; c.index = 8'd0; c.value = 8'd0;
        exp_cmd.push_back(c);
        @(negedge clk);
        req0_valid = 1'b1; req0_cmd = 3'd1; req0_index = 8'd0; req0_value = 8'd0;
        repeat (5) @(negedge clk);
        checkOutput("busy_before_reset", 32'(sched_busy), 32'd1);
        rst = 1'b1;
        model_clear = 1'b1;
        req0_valid = 1'b0;
        #1;
        checkOutput("midrst_req0_ack", 32'(req0_ack), 32'd0);
        checkOutput("midrst_req0_err", 32'(req0_err), 32'd0);
        checkOutput("midrst_cmd_valid", 32'(mpq_bus.mpq_cmd_valid), 32'd0);
        checkOutput("midrst_mpq_cmd", 32'(mpq_bus.mpq_cmd), 32'd0);
        checkOutput("midrst_occ", 32'(occ), 32'd0);
        checkOutput("midrst_sched_busy", 32'(sched_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_after_reset", 32'(sched_busy), 32'd0);

        busy_len = 1;
        load_occ(8'd2);
        applyStimulus(1'b1, 3'd1, 8'd0, 8'd0, 1'b0, 1'b1, 8'd1, lat);

        repeat (3) @(negedge clk);
        checkOutput("exp_cmd_drained", 32'(exp_cmd.size()), 32'd0);
        checkOutput("exp_ack_drained", 32'(exp_ack.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mpq_sched.md
Name: mpq_sched

Overview:
Command scheduler placed in front of the max-priority-queue datapath. It arbitrates two requester ports round-robin and issues one queue command at a time on the queue's cmd_valid/cmd/index/value interface. It then tracks busy/done until the command completes and returns a one-cycle ack with an error flag. It keeps a shadow occupancy count so that illegal commands (extract on empty, insert on full, out-of-range increase) are rejected before they reach the queue.

Parameters:
DEPTH, 255, maximum element count the queue accepts; insert is rejected when occ == DEPTH
BUSY_TO, 4, cycles to wait for mpq_busy to rise after issue before flagging timeout
OCC_W, 8, width of the occupancy counter

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req0_valid  in  1  requester 0 command request; held until req0_ack
req0_cmd  in  3  0=build, 1=extract, 2=increase, 3=insert, 4=write-out, 5-7 illegal
req0_index  in  8  element index (increase only)
req0_value  in  8  new value (increase/insert)
req0_ack  out  1  one-cycle completion pulse
req0_err  out  1  valid with req0_ack; 1 = rejected or timed out
req1_valid, req1_cmd, req1_index, req1_value, req1_ack, req1_err  same as requester 0
occ_init_valid  in  1  load the shadow occupancy (after a bulk data load)
occ_init  in  OCC_W  occupancy value to load
mpq_cmd_valid  out  1  one-cycle command strobe to the queue
mpq_cmd  out  3  command code
mpq_index  out  8  index to the queue
mpq_value  out  8  value to the queue
mpq_busy  in  1  queue busy
mpq_done  in  1  queue write-out complete
occ  out  OCC_W  shadow occupancy
sched_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, occ=0, state IDLE, last_grant=1 (requester 0 wins the first tie). Reset mid-operation aborts the command with no ack. The queue is not notified.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_CMPL, RESP.
- IDLE, occ_init_valid=1: load occ <= occ_init. Requests are ignored that cycle.
- IDLE, one valid request: grant it. With both valid, grant the requester != last_grant, then update last_grant. Latch cmd, index and value.
- Validation happens at grant. A command is rejected if:
  - cmd >= 5;
  - cmd=1 and occ==0;
  - cmd=3 and occ==DEPTH;
  - cmd=2 and index >= occ.
- A rejected command goes straight to RESP with err=1. mpq_cmd_valid is never asserted.
- ISSUE: mpq_cmd_valid=1 for exactly one cycle with the latched fields, then WAIT_BUSY.
- WAIT_BUSY:
  - Counts cycles. mpq_busy=1 moves to WAIT_CMPL.
  - Counter reaching BUSY_TO moves to RESP with err=1, and occ is unchanged.
- WAIT_CMPL:
  - cmd=4: wait for mpq_done=1.
  - Other commands: wait for mpq_busy=0.
  - No timeout.
  - On completion, insert does occ+1 and extract does occ-1; other commands leave occ unchanged. Then go to RESP with err=0.
- RESP: reqN_ack=1 and reqN_err for the granted requester only, for one cycle, then IDLE.
- Requesters must drop or change valid the cycle after ack. A request still valid in the IDLE cycle after RESP is treated as a new request.
- Minimum latency from grant to ack:
  - Rejected: 2 cycles (grant in IDLE, ack in RESP).
  - Accepted: 5 cycles with a one-cycle queue operation.
- occ never wraps; the rejection rules guarantee 0 <= occ <= DEPTH.

Optional Feature:
MPQ_SCHED_STATS_EN:
- Defined: adds outputs grant_cnt0 and grant_cnt1 (16 bits each) and err_cnt (16 bits).
  - grant_cnt0/grant_cnt1 increment on each ack to that requester.
  - err_cnt increments on each ack with err=1.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- occ_init_valid with occ_init=5, then req0 cmd=3 value=8'h40 with the queue model raising busy for 3 cycles -> mpq_cmd_valid pulse with cmd=3, value=8'h40; req0_ack with err=0; occ=6.
- occ=0, req1 cmd=1 -> req1_ack with err=1 two cycles after grant; mpq_cmd_valid never asserted; occ stays 0.
- req0 and req1 both valid with cmd=0 in the same cycle from reset -> req0 served first, then req1; the next tie goes to req0; exactly one ack per command.
- Queue model never raises busy, BUSY_TO=4 -> ack with err=1 after 4 WAIT_BUSY cycles; occ unchanged.
- occ=3, req0 cmd=2 index=3 -> rejected (err=1); index=2 value=8'hFF -> issued, ack err=0; cmd=4 waits for mpq_done, and ack follows done by 1 cycle.
- rst asserted during WAIT_CMPL -> all outputs 0 immediately; occ=0; no ack is produced; the next request is serviced normally.
